// File: rtl/hocs_thermal_frontend.sv
// hocs_thermal_frontend
// Conditions raw 8-bit die-temperature ADC samples for the SCRAM controller.
// Moving-average filter, rail-code rejection, persistence-qualified alarm
// with hysteresis and a sample-timeout watchdog. Any sensor fault latches a
// fail-safe full-scale temperature so the downstream trip path fires on its own.

module hocs_thermal_frontend #(
  parameter int unsigned AVG_LOG2       = 3,
  parameter logic [31:0] SAMPLE_TIMEOUT = 32'd3_000_000,
  parameter logic [7:0]  ALARM_LIMIT    = 8'd200,
  parameter logic [7:0]  ALARM_HYST     = 8'd10,
  parameter logic [3:0]  ALARM_PERSIST  = 4'd4,
  parameter logic [2:0]  RAIL_PERSIST   = 3'd4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       adc_valid,
  input  logic [7:0] adc_data,
  output logic       adc_ready,
  output logic [7:0] temp_filtered,
  output logic       temp_valid,
  output logic       thermal_alarm,
  output logic       sensor_fault
);

  localparam int unsigned WIN = 32'd1 << AVG_LOG2;
  localparam int unsigned SW  = 32'd8 + AVG_LOG2;
  localparam logic [AVG_LOG2-1:0] PTR_LAST  = AVG_LOG2'(WIN - 32'd1);
  localparam logic [AVG_LOG2-1:0] PTR_ONE   = AVG_LOG2'(32'd1);
  localparam logic [7:0]          CLR_LEVEL = ALARM_LIMIT - ALARM_HYST;

  localparam logic [1:0] ST_FILL  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  // Registers
  logic [1:0]          r_state;
  logic [AVG_LOG2-1:0] r_wr_ptr;
  logic [SW-1:0]       r_sum;
  logic [2:0]          r_rail_cnt;
  logic [31:0]         r_tmo_cnt;
  logic [3:0]          r_persist;
  logic                r_adc_ready;
  logic [7:0]          r_temp_filtered;
  logic                r_temp_valid;
  logic                r_thermal_alarm;
  logic                r_sensor_fault;
  logic [7:0]          r_buf [WIN];

  // Wires
  logic                w_accept;
  logic                w_is_rail;
  logic                w_data_acc;
  logic                w_rail_acc;
  logic [7:0]          w_oldest;
  logic [SW-1:0]       w_sum_next;
  logic [7:0]          w_avg;
  logic                w_fill_done;
  logic                w_use_avg;
  logic                w_rail_trip;
  logic                w_tmo_trip;
  logic                w_fault_entry;
  logic [1:0]          w_state_next;
  logic [3:0]          w_persist_inc;

  assign w_accept   = adc_valid && r_adc_ready;
  assign w_is_rail  = (adc_data == 8'h00) || (adc_data == 8'hFF);
  assign w_data_acc = w_accept && !w_is_rail;
  assign w_rail_acc = w_accept && w_is_rail;

  // During FILL the slot being overwritten holds stale data, so it must not be subtracted.
  assign w_oldest    = (r_state == ST_RUN) ? r_buf[r_wr_ptr] : 8'h00;
  assign w_sum_next  = r_sum + {{AVG_LOG2{1'b0}}, adc_data} - {{AVG_LOG2{1'b0}}, w_oldest};
  assign w_avg       = w_sum_next[SW-1:AVG_LOG2];
  assign w_fill_done = (r_state == ST_FILL) && (r_wr_ptr == PTR_LAST);
  assign w_use_avg   = (r_state == ST_RUN) || w_fill_done;

  // A sample arriving on the very cycle the watchdog would expire keeps the sensor alive.
  assign w_rail_trip   = w_rail_acc && ((r_rail_cnt + 3'd1) == RAIL_PERSIST);
  assign w_tmo_trip    = !w_accept && (r_tmo_cnt == SAMPLE_TIMEOUT);
  assign w_fault_entry = (r_state != ST_FAULT) && (w_rail_trip || w_tmo_trip);

  assign w_persist_inc = (r_persist < ALARM_PERSIST) ? (r_persist + 4'd1) : r_persist;

  // Next-state selection; an unknown encoding falls into FAULT.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_FILL: begin
        if (w_fault_entry) begin
          w_state_next = ST_FAULT;
        end else if (w_data_acc && w_fill_done) begin
          w_state_next = ST_RUN;
        end else begin
          w_state_next = ST_FILL;
        end
      end
      ST_RUN: begin
        if (w_fault_entry) begin
          w_state_next = ST_FAULT;
        end else begin
          w_state_next = ST_RUN;
        end
      end
      ST_FAULT: w_state_next = ST_FAULT;
      default:  w_state_next = ST_FAULT;
    endcase
  end

  // State, handshake and conditioned-temperature output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state         <= ST_FILL;
      r_adc_ready     <= 1'b0;
      r_temp_filtered <= 8'h00;
      r_temp_valid    <= 1'b0;
      r_sensor_fault  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_adc_ready <= (w_state_next != ST_FAULT);
      if (w_state_next == ST_FAULT) begin
        r_temp_filtered <= 8'hFF;
        r_temp_valid    <= 1'b0;
        r_sensor_fault  <= 1'b1;
      end else begin
        r_temp_valid   <= w_data_acc;
        r_sensor_fault <= 1'b0;
        if (w_data_acc) begin
          r_temp_filtered <= w_use_avg ? w_avg : adc_data;
        end else begin
          r_temp_filtered <= r_temp_filtered;
        end
      end
    end
  end

  // Running sum, write pointer, rail-persistence and watchdog counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sum      <= '0;
      r_wr_ptr   <= '0;
      r_rail_cnt <= 3'd0;
      r_tmo_cnt  <= 32'd0;
    end else begin
      if (w_data_acc) begin
        r_sum    <= w_sum_next;
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end else begin
        r_sum    <= r_sum;
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_rail_acc) begin
        r_rail_cnt <= r_rail_cnt + 3'd1;
      end else if (w_data_acc) begin
        r_rail_cnt <= 3'd0;
      end else begin
        r_rail_cnt <= r_rail_cnt;
      end
      if (w_accept) begin
        r_tmo_cnt <= 32'd0;
      end else if (r_state != ST_FAULT) begin
        r_tmo_cnt <= r_tmo_cnt + 32'd1;
      end else begin
        r_tmo_cnt <= r_tmo_cnt;
      end
    end
  end

  // Sample buffer; deliberately not cleared by reset since FILL never reads stale slots.
  always_ff @(posedge clk) begin
    if (rst_n && w_data_acc) begin
      r_buf[r_wr_ptr] <= adc_data;
    end
  end

  // Alarm qualification on each fresh filtered value; forced high while faulted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_persist       <= 4'd0;
      r_thermal_alarm <= 1'b0;
    end else if (w_state_next == ST_FAULT) begin
      r_persist       <= r_persist;
      r_thermal_alarm <= 1'b1;
    end else if (r_temp_valid) begin
      if (r_temp_filtered > ALARM_LIMIT) begin
        r_persist <= w_persist_inc;
        if (w_persist_inc == ALARM_PERSIST) begin
          r_thermal_alarm <= 1'b1;
        end else begin
          r_thermal_alarm <= r_thermal_alarm;
        end
      end else if (r_temp_filtered <= CLR_LEVEL) begin
        r_persist       <= 4'd0;
        r_thermal_alarm <= 1'b0;
      end else begin
        r_persist       <= 4'd0;
        r_thermal_alarm <= r_thermal_alarm;
      end
    end else begin
      r_persist       <= r_persist;
      r_thermal_alarm <= r_thermal_alarm;
    end
  end

  assign adc_ready     = r_adc_ready;
  assign temp_filtered = r_temp_filtered;
  assign temp_valid    = r_temp_valid;
  assign thermal_alarm = r_thermal_alarm;
  assign sensor_fault  = r_sensor_fault;

endmodule

// File: tb/tb_hocs_thermal_frontend.sv
// Self-checking bench for hocs_thermal_frontend: a sample-history reference
// model compared against the DUT every cycle, plus literal expectations.

module tb_hocs_thermal_frontend;

  localparam int TMO = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       adc_valid = 1'b0;
  logic [7:0] adc_data = 8'h00;
  logic       adc_ready;
  logic [7:0] temp_filtered;
  logic       temp_valid;
  logic       thermal_alarm;
  logic       sensor_fault;

  int n_vec = 0;
  int n_err = 0;

  hocs_thermal_frontend #(
    .AVG_LOG2(3),
    .SAMPLE_TIMEOUT(32'd100),
    .ALARM_LIMIT(8'd200),
    .ALARM_HYST(8'd10),
    .ALARM_PERSIST(4'd4),
    .RAIL_PERSIST(3'd4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .adc_valid(adc_valid),
    .adc_data(adc_data),
    .adc_ready(adc_ready),
    .temp_filtered(temp_filtered),
    .temp_valid(temp_valid),
    .thermal_alarm(thermal_alarm),
    .sensor_fault(sensor_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int expv);
    n_vec++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit   started = 1'b0;
  int   hist[$];
  int   m_rail, m_idle, m_persist;
  bit   m_fault;
  int   e_ready, e_valid, e_alarm, e_fault, e_filt;
  int   cap[$];

  task automatic set_fault_outputs();
    e_ready = 0; e_valid = 0; e_filt = 255; e_alarm = 1; e_fault = 1;
  endtask

  task automatic model_step();
    int d, na, s;
    bit acc, nv, go_fault;
    if (!rst_n) begin
      hist.delete();
      m_rail = 0; m_idle = 0; m_persist = 0; m_fault = 1'b0;
      e_ready = 0; e_valid = 0; e_filt = 0; e_alarm = 0; e_fault = 0;
    end else if (m_fault) begin
      set_fault_outputs();
    end else begin
      na = e_alarm;
      if (e_valid != 0) begin
        if (e_filt > 200) begin
          if (m_persist < 4) m_persist++;
          if (m_persist == 4) na = 1;
        end else if (e_filt <= 190) begin
          na = 0; m_persist = 0;
        end else begin
          m_persist = 0;
        end
      end
      acc = adc_valid && (e_ready != 0);
      d = int'(adc_data);
      nv = 1'b0; go_fault = 1'b0;
      if (acc) begin
        m_idle = 0;
        if (d == 0 || d == 255) begin
          m_rail++;
          if (m_rail == 4) go_fault = 1'b1;
        end else begin
          m_rail = 0;
          hist.push_back(d);
          if (hist.size() > 8) void'(hist.pop_front());
          nv = 1'b1;
        end
      end else begin
        if (m_idle == TMO) go_fault = 1'b1;
        else m_idle++;
      end
      if (go_fault) begin
        m_fault = 1'b1;
        set_fault_outputs();
      end else begin
        e_ready = 1; e_valid = nv; e_alarm = na; e_fault = 0;
        if (nv) begin
          if (hist.size() < 8) begin
            e_filt = d;
          end else begin
            s = 0;
            foreach (hist[i]) s += hist[i];
            e_filt = s / 8;
          end
        end
      end
    end
    started = 1'b1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Compare process: all outputs against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        check("adc_ready", int'(adc_ready), e_ready);
        check("temp_valid", int'(temp_valid), e_valid);
        check("temp_filtered", int'(temp_filtered), e_filt);
        check("thermal_alarm", int'(thermal_alarm), e_alarm);
        check("sensor_fault", int'(sensor_fault), e_fault);
        if (temp_valid) cap.push_back(int'(temp_filtered));
      end
    end
  end

  // ---------------- stimulus ----------------
  int ramp_exp [17] = '{117, 135, 152, 170, 187, 205, 222, 240, 240,
                        233, 226, 219, 212, 205, 198, 191, 185};

  task automatic send(input logic [7:0] d);
    adc_valid = 1'b1;
    adc_data  = d;
    @(posedge clk); #1;
    adc_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic pin_cap(input string nm, input int idx, input int expv);
    if (cap.size() > idx) check(nm, cap[idx], expv);
    else check({nm, "_missing"}, cap.size(), idx + 1);
  endtask

  task automatic do_reset();
    adc_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_ready", int'(adc_ready), 0);
    check("rst_filt", int'(temp_filtered), 0);
    check("rst_valid", int'(temp_valid), 0);
    check("rst_alarm", int'(thermal_alarm), 0);
    check("rst_fault", int'(sensor_fault), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", int'(adc_ready), 1);
    cap.delete();
  endtask

  initial begin
    int k;
    bit seen;
    idle(2);
    do_reset();

    // Fill with a constant: pass-through then average, both 100.
    for (int i = 0; i < 8; i++) send(8'd100);
    settle();
    check("fill_count", cap.size(), 8);
    for (int i = 0; i < 8; i++) pin_cap("fill_val", i, 100);

    // Step to 240, then back to 185: ramp, persistence and hysteresis.
    cap.delete();
    for (int i = 0; i < 8; i++) send(8'd240);
    idle(1);
    check("alarm_3_over", int'(thermal_alarm), 0);
    send(8'd240);
    idle(1);
    check("alarm_4_over", int'(thermal_alarm), 1);
    for (int i = 0; i < 7; i++) send(8'd185);
    idle(1);
    check("alarm_hyst_hold", int'(thermal_alarm), 1);
    send(8'd185);
    idle(1);
    check("alarm_cleared", int'(thermal_alarm), 0);
    for (int i = 0; i < 17; i++) pin_cap("ramp", i, ramp_exp[i]);

    // Reset mid-RUN; FILL pass-through resumes.
    do_reset();
    send(8'd37);
    settle();
    pin_cap("post_rst_pass", 0, 37);

    // Wrap-around with 1..20.
    do_reset();
    for (int i = 1; i <= 20; i++) send(8'(i));
    settle();
    pin_cap("wrap_first_avg", 7, 4);
    pin_cap("wrap_final", 19, 16);

    // Rail codes are dropped from the average and qualified by persistence.
    do_reset();
    for (int i = 0; i < 3; i++) send(8'hFF);
    send(8'd90);
    for (int i = 0; i < 3; i++) send(8'h00);
    for (int i = 0; i < 7; i++) send(8'd50);
    settle();
    pin_cap("rail_pass", 0, 90);
    pin_cap("rail_avg", 7, 55);
    check("rail_count_valid", cap.size(), 8);
    for (int i = 0; i < 3; i++) send(8'h00);
    check("rail3_no_fault", int'(sensor_fault), 0);
    send(8'h00);
    check("rail4_fault", int'(sensor_fault), 1);
    check("rail4_filt", int'(temp_filtered), 255);
    check("rail4_ready", int'(adc_ready), 0);
    check("rail4_alarm", int'(thermal_alarm), 1);
    idle(3);
    check("fault_sticky", int'(sensor_fault), 1);

    // Reset mid-FAULT.
    do_reset();
    send(8'd77);
    settle();
    pin_cap("post_fault_pass", 0, 77);

    // Timeout: fault appears exactly 101 cycles after the last accept.
    do_reset();
    send(8'd10); send(8'd20); send(8'd30);
    k = 0; seen = 1'b0;
    while (!seen && k < 200) begin
      @(posedge clk); #1;
      k++;
      if (sensor_fault) seen = 1'b1;
    end
    check("tmo_seen", int'(seen), 1);
    check("tmo_cycles", k, 101);
    check("tmo_filt", int'(temp_filtered), 255);
    check("tmo_ready", int'(adc_ready), 0);

    // Sample on the expiry cycle wins.
    do_reset();
    send(8'd10); send(8'd20); send(8'd30);
    idle(100);
    check("tmo_edge_ready", int'(adc_ready), 1);
    send(8'd40);
    idle(5);
    check("tmo_edge_no_fault", int'(sensor_fault), 0);
    settle();
    pin_cap("tmo_edge_pass", 3, 40);

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
